// File: rtl/wm_pkg.sv
// rtl/wm_pkg.sv - shared types and constants for the washing-machine sequencer
package wm_pkg;

    localparam int WM_TW       = 5;
    localparam int WM_MAX_LOAD = 24;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FILL  = 3'd1,
        ST_WASH  = 3'd2,
        ST_RINSE = 3'd3,
        ST_SPIN  = 3'd4,
        ST_DONE  = 3'd5,
        ST_FAULT = 3'd6
    } wm_state_t;

    // Fill time grows with the load: one time unit per four load steps, plus one.
    function automatic logic [WM_TW-1:0] fill_time(input logic [WM_TW-1:0] load);
        return (load >> 2) + WM_TW'(1);
    endfunction

endpackage

// File: rtl/wm_tick_gen.sv
// rtl/wm_tick_gen.sv - prescaler producing one tick every TICK_DIV cycles
module wm_tick_gen #(
    parameter int TICK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic hold,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] count;

    // Count 0..TICK_DIV-1; clear wins over hold so a new phase always starts from zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (hold) begin
            count <= count;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

    // A frozen prescaler must not tick, otherwise a paused phase would still shorten.
    assign tick = (count == LAST) && !hold;

endmodule

// File: rtl/wm_cycle_sequencer.sv
// rtl/wm_cycle_sequencer.sv - washing-machine programme FSM with timed phases
module wm_cycle_sequencer
    import wm_pkg::*;
#(
    parameter int TICK_DIV = 4,
    parameter int MAX_LOAD = WM_MAX_LOAD
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             pause,
    input  logic             abort,
    input  logic [WM_TW-1:0] wash_time,
    input  logic [WM_TW-1:0] rinse_time,
    input  logic [WM_TW-1:0] spin_time,
    input  logic [WM_TW-1:0] cloth_load,
    output logic [2:0]       state,
    output logic [WM_TW-1:0] remaining,
    output logic             water_in,
    output logic             motor_on,
    output logic             busy,
    output logic             done,
    output logic             fault
);

    localparam logic [WM_TW-1:0] MAX_LOAD_V = WM_TW'(MAX_LOAD);

    wm_state_t        cur;
    wm_state_t        nxt;
    logic [WM_TW-1:0] rem;
    logic [WM_TW-1:0] rem_next;
    logic [WM_TW-1:0] wash_q;
    logic [WM_TW-1:0] rinse_q;
    logic [WM_TW-1:0] spin_q;
    logic             latch;
    logic             tick;
    logic             active;
    logic             hold_phase;
    logic             clear;
    logic             phase_end;

    assign active     = (cur == ST_FILL) || (cur == ST_WASH) ||
                        (cur == ST_RINSE) || (cur == ST_SPIN);
    assign hold_phase = active && pause && !abort;
    // Outside a phase, and in the single cycle of a zero-length phase, keep the prescaler at zero.
    assign clear      = !active || (rem == '0) || abort;
    assign phase_end  = (rem == '0) || (tick && (rem == WM_TW'(1)));

    wm_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .hold  (hold_phase),
        .tick  (tick)
    );

    // Next state and next remaining-time, with abort over pause over normal stepping.
    always_comb begin
        nxt      = cur;
        rem_next = rem;
        latch    = 1'b0;
        unique case (cur)
            ST_IDLE: begin
                if (start) begin
                    latch = 1'b1;
                    if (cloth_load > MAX_LOAD_V) begin
                        nxt = ST_FAULT;
                    end else begin
                        nxt      = ST_FILL;
                        rem_next = fill_time(cloth_load);
                    end
                end
            end
            ST_FILL, ST_WASH, ST_RINSE, ST_SPIN: begin
                if (abort) begin
                    nxt      = ST_IDLE;
                    rem_next = '0;
                end else if (pause) begin
                    nxt      = cur;
                    rem_next = rem;
                end else if (phase_end) begin
                    unique case (cur)
                        ST_FILL: begin
                            nxt      = ST_WASH;
                            rem_next = wash_q;
                        end
                        ST_WASH: begin
                            nxt      = ST_RINSE;
                            rem_next = rinse_q;
                        end
                        ST_RINSE: begin
                            nxt      = ST_SPIN;
                            rem_next = spin_q;
                        end
                        default: begin
                            nxt      = ST_DONE;
                            rem_next = '0;
                        end
                    endcase
                end else if (tick) begin
                    rem_next = rem - WM_TW'(1);
                end
            end
            ST_DONE: begin
                nxt      = ST_IDLE;
                rem_next = '0;
            end
            ST_FAULT: begin
                if (abort) begin
                    nxt      = ST_IDLE;
                    rem_next = '0;
                end
            end
            default: begin
                nxt      = ST_IDLE;
                rem_next = '0;
            end
        endcase
    end

    // State, timer, preset latches and the registered valve/motor enables.
    // Cloth load only matters in the start cycle, so it is consumed directly there.
    always_ff @(posedge clk) begin
        if (rst) begin
            cur      <= ST_IDLE;
            rem      <= '0;
            wash_q   <= '0;
            rinse_q  <= '0;
            spin_q   <= '0;
            water_in <= 1'b0;
            motor_on <= 1'b0;
        end else begin
            cur      <= nxt;
            rem      <= rem_next;
            if (latch) begin
                wash_q  <= wash_time;
                rinse_q <= rinse_time;
                spin_q  <= spin_time;
            end
            water_in <= (nxt == ST_FILL) && !hold_phase;
            motor_on <= ((nxt == ST_WASH) || (nxt == ST_RINSE) || (nxt == ST_SPIN)) && !hold_phase;
        end
    end

    assign state     = cur;
    assign remaining = rem;
    assign busy      = active;
    assign done      = (cur == ST_DONE);
    assign fault     = (cur == ST_FAULT);

endmodule

// File: tb/tb_wm_cycle_sequencer.sv
// tb/tb_wm_cycle_sequencer.sv - scoreboard bench for wm_cycle_sequencer
module tb_wm_cycle_sequencer;

    localparam int TD = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       pause = 1'b0;
    logic       abort = 1'b0;
    logic [4:0] wash_time = '0;
    logic [4:0] rinse_time = '0;
    logic [4:0] spin_time = '0;
    logic [4:0] cloth_load = '0;
    logic [2:0] state;
    logic [4:0] remaining;
    logic       water_in, motor_on, busy, done, fault;

    wm_cycle_sequencer #(.TICK_DIV(TD), .MAX_LOAD(24)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .pause      (pause),
        .abort      (abort),
        .wash_time  (wash_time),
        .rinse_time (rinse_time),
        .spin_time  (spin_time),
        .cloth_load (cloth_load),
        .state      (state),
        .remaining  (remaining),
        .water_in   (water_in),
        .motor_on   (motor_on),
        .busy       (busy),
        .done       (done),
        .fault      (fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         st;
        int         rem;
        logic [4:0] flags;
        int         e;
    } exp_t;

    exp_t sbq[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   edge_n = 0;
    int   start_e = 0;
    int   done_e = -1;
    int   done_cnt = 0;

    task automatic chk(input string nm, input int act, input int exp_v, input int e);
        n_cmp++;
        if (act != exp_v) begin
            n_bad++;
            $display("FAIL %s at edge %0d: got %0d expected %0d", nm, e, act, exp_v);
        end
    endtask

    // Reference model: a phase of D units lasts D*TD unpaused cycles (one if D is zero),
    // and the time left is D minus the whole units already elapsed.
    initial begin : model
        int ms, md, mel, lw, lr, ls;
        bit mp;
        exp_t x;
        ms = 0; md = 0; mel = 0; lw = 0; lr = 0; ls = 0; mp = 0;
        forever begin
            @(posedge clk);
            edge_n++;
            mp = 0;
            if (rst) begin
                ms = 0; md = 0; mel = 0; lw = 0; lr = 0; ls = 0;
            end else begin
                case (ms)
                    0: if (start) begin
                        lw = int'(wash_time); lr = int'(rinse_time); ls = int'(spin_time);
                        start_e = edge_n;
                        if (int'(cloth_load) > 24) ms = 6;
                        else begin
                            ms = 1; md = int'(cloth_load) / 4 + 1; mel = 0;
                        end
                    end
                    1, 2, 3, 4: begin
                        if (abort) ms = 0;
                        else if (pause) mp = 1;
                        else begin
                            mel++;
                            if (md == 0 || mel == md * TD) begin
                                ms++;
                                mel = 0;
                                md = (ms == 2) ? lw : (ms == 3) ? lr : (ms == 4) ? ls : 0;
                            end
                        end
                    end
                    5: ms = 0;
                    default: if (abort) ms = 0;
                endcase
            end
            x.st    = ms;
            x.rem   = (ms >= 1 && ms <= 4) ? (md - mel / TD) : 0;
            x.flags = {(ms == 1) && !mp, (ms >= 2 && ms <= 4) && !mp,
                       (ms >= 1 && ms <= 4), ms == 5, ms == 6};
            x.e     = edge_n;
            sbq.push_back(x);
        end
    end

    // Monitor: every cycle the DUT presents a new registered output set.
    initial begin : monitor
        exp_t x;
        forever begin
            @(negedge clk);
            if (sbq.size() > 0) begin
                x = sbq.pop_front();
                chk("state", int'(state), x.st, x.e);
                chk("remaining", int'(remaining), x.rem, x.e);
                chk("flags{water,motor,busy,done,fault}",
                    int'({water_in, motor_on, busy, done, fault}), int'(x.flags), x.e);
                if (done) begin
                    done_e = x.e;
                    done_cnt++;
                end
            end
        end
    end

    task automatic run_prog(input int w, input int r, input int sp, input int cl,
                            input int pl, input int ph, input int ab, input int rs,
                            input int sm, input int wc, input int n);
        wash_time  = 5'(w);
        rinse_time = 5'(r);
        spin_time  = 5'(sp);
        cloth_load = 5'(cl);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= n; k++) begin
            pause = (k >= pl) && (k <= ph);
            abort = (k == ab);
            rst   = (k == rs);
            start = (k == sm);
            if (k == wc) wash_time = 5'($urandom_range(31, 6));
            @(negedge clk);
        end
        pause = 1'b0; abort = 1'b0; rst = 1'b0; start = 1'b0;
        @(negedge clk);
        #1;
    endtask

    initial begin : driver
        int dc;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        dc = done_cnt;
        run_prog(2, 1, 3, 8, 0, -1, -1, -1, -1, -1, 40);
        chk("nominal_done_count", done_cnt - dc, 1, edge_n);
        chk("nominal_done_cycle", done_e - start_e + 1, 37, edge_n);

        dc = done_cnt;
        run_prog(2, 1, 3, 25, 0, -1, 3, -1, -1, -1, 4);
        chk("overload_no_done", done_cnt - dc, 0, edge_n);

        run_prog(0, 0, 0, 0, 0, -1, -1, -1, -1, -1, 10);
        chk("zero_done_cycle", done_e - start_e + 1, 8, edge_n);

        run_prog(2, 1, 3, 8, 15, 19, -1, -1, -1, -1, 45);
        chk("pause_done_cycle", done_e - start_e + 1, 42, edge_n);

        dc = done_cnt;
        run_prog(2, 1, 3, 8, 0, -1, 22, -1, -1, -1, 30);
        chk("abort_no_done", done_cnt - dc, 0, edge_n);

        dc = done_cnt;
        run_prog(2, 1, 3, 8, 10, 10, -1, 10, -1, -1, 5);
        chk("rst_no_done", done_cnt - dc, 0, edge_n);
        run_prog(2, 1, 3, 8, 0, -1, -1, -1, -1, -1, 40);
        chk("after_rst_done_cycle", done_e - start_e + 1, 37, edge_n);

        run_prog(2, 1, 3, 8, 0, -1, -1, -1, 16, 14, 40);
        chk("ignored_inputs_done_cycle", done_e - start_e + 1, 37, edge_n);

        for (int i = 0; i < 6000; i++) begin
            start = ($urandom % 12) == 0;
            pause = ($urandom % 6) == 0;
            abort = ($urandom % 60) == 0;
            rst   = ($urandom % 700) == 0;
            wash_time  = (($urandom % 10) == 0) ? 5'($urandom) : 5'($urandom % 6);
            rinse_time = (($urandom % 10) == 0) ? 5'($urandom) : 5'($urandom % 6);
            spin_time  = (($urandom % 10) == 0) ? 5'($urandom) : 5'($urandom % 6);
            cloth_load = 5'($urandom);
            @(negedge clk);
        end
        start = 1'b0; pause = 1'b0; abort = 1'b0; rst = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("scoreboard_drained", sbq.size(), 0, edge_n);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
